fa_v1: RTL and testbench

- Parameterised full adder: WIDTH-bit ripple-carry chain of 1-bit full-adder cells, with registered outputs.
- Default WIDTH=1 gives the classic 1-bit full adder: sum = a ^ b ^ c_in, c_out = majority(a, b, c_in).
- Sits in the arithmetic datapath as the basic add primitive; one clock domain.

---
 rtl/fa_v1_pkg.sv | 19 +
 rtl/fa_v1_cell.sv | 15 +
 rtl/fa_v1.sv | 98 +++++++++
 tb/tb_fa_v1.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fa_v1_pkg.sv
// Shared constants and golden-model helper for the fa_v1 ripple-carry adder.
// Optional feature macro: FA_V1_OVERFLOW_EN (signed overflow output).
package fa_v1_pkg;

  localparam int unsigned FA_V1_MAX_WIDTH = 64;

  // Full-width reference sum. Callers zero-extend narrower operands and take
  // bits [WIDTH:0] as {cout, sum}.
  function automatic logic [FA_V1_MAX_WIDTH:0] fa_v1_ref(
    input logic [FA_V1_MAX_WIDTH-1:0] a,
    input logic [FA_V1_MAX_WIDTH-1:0] b,
    input logic                       cin
  );
    logic [FA_V1_MAX_WIDTH:0] res;
    res = {1'b0, a} + {1'b0, b} + {{FA_V1_MAX_WIDTH{1'b0}}, cin};
    return res;
  endfunction

endpackage

// File: rtl/fa_v1_cell.sv
// Combinational 1-bit full adder cell; chained by fa_v1 into a ripple-carry adder.
module fa_v1_cell
  import fa_v1_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/fa_v1.sv
// WIDTH-bit ripple-carry adder with registered sum/carry and a one-cycle valid strobe.
// Optional: define FA_V1_OVERFLOW_EN to add the registered signed-overflow output ovf.
module fa_v1
  import fa_v1_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             out_valid
`ifdef FA_V1_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  if (WIDTH < 1 || WIDTH > FA_V1_MAX_WIDTH) begin : g_bad_width
    $error("fa_v1: WIDTH must be within 1..64");
  end

  // carry[i] is the carry into bit i; carry[WIDTH] is the final carry out.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;

  assign carry[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_v1_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .c_in (carry[i]),
      .sum  (sum_comb[i]),
      .c_out(carry[i+1])
    );
  end

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             c_out_d, c_out_q;
  logic             valid_d, valid_q;

  // Inputs are only looked at when in_valid is high, so X/Z on idle cycles
  // cannot reach the registers.
  always_comb begin
    sum_d   = sum_q;
    c_out_d = c_out_q;
    valid_d = 1'b0;
    if (in_valid) begin
      sum_d   = sum_comb;
      c_out_d = carry[WIDTH];
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      c_out_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      valid_q <= valid_d;
    end
  end

  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign out_valid = valid_q;

`ifdef FA_V1_OVERFLOW_EN
  logic ovf_d, ovf_q;

  // Signed overflow: carry into the MSB differs from carry out of it.
  always_comb begin
    ovf_d = ovf_q;
    if (in_valid) begin
      ovf_d = carry[WIDTH] ^ carry[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_fa_v1.sv
// Scoreboard bench for fa_v1 at WIDTH=1 and WIDTH=8; checks ovf when FA_V1_OVERFLOW_EN is set.
module tb_fa_v1;
  import fa_v1_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       v1, a1, b1, c1, s1, co1, vo1;
  logic       v8, c8, co8, vo8;
  logic [7:0] a8, b8, s8;
`ifdef FA_V1_OVERFLOW_EN
  logic       of1, of8;
`endif

  fa_v1 #(.WIDTH(1)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (v1),
    .a        (a1),
    .b        (b1),
    .c_in     (c1),
    .sum      (s1),
    .c_out    (co1),
    .out_valid(vo1)
`ifdef FA_V1_OVERFLOW_EN
    ,
    .ovf      (of1)
`endif
  );

  fa_v1 #(.WIDTH(8)) u_dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (v8),
    .a        (a8),
    .b        (b8),
    .c_in     (c8),
    .sum      (s8),
    .c_out    (co8),
    .out_valid(vo8)
`ifdef FA_V1_OVERFLOW_EN
    ,
    .ovf      (of8)
`endif
  );

  typedef struct packed {
    logic       ovf;
    logic       c;
    logic [7:0] s;
  } exp_t;

  exp_t q1[$];
  exp_t q8[$];
  exp_t last1 = '0;
  exp_t last8 = '0;
  int   errors = 0;
  int   checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Independent model: signed overflow when operand signs agree and result sign differs.
  function automatic exp_t exp8(input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [FA_V1_MAX_WIDTH:0] r;
    exp_t e;
    r     = fa_v1_ref({56'd0, a}, {56'd0, b}, c);
    e.s   = r[7:0];
    e.c   = r[8];
    e.ovf = (a[7] == b[7]) && (r[7] != a[7]);
    return e;
  endfunction

  task automatic step1(input logic v, input logic a, input logic b, input logic c,
                       input exp_t e);
    @(negedge clk);
    v1 = v; a1 = a; b1 = b; c1 = c;
    if (v && rst_n) q1.push_back(e);
  endtask

  task automatic step8(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input exp_t e);
    @(negedge clk);
    v8 = v; a8 = a; b8 = b; c8 = c;
    if (v && rst_n) q8.push_back(e);
  endtask

  // Results appear on the output registers just after the capturing edge.
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      check_eq("rst1", {vo1, co1, s1}, 64'd0);
      last1 = '0;
    end else if (vo1) begin
      if (q1.size() == 0) begin
        check_eq("spurious_valid1", vo1, 64'd0);
      end else begin
        e = q1.pop_front();
        check_eq("sum1", s1, e.s[0]);
        check_eq("cout1", co1, e.c);
`ifdef FA_V1_OVERFLOW_EN
        check_eq("ovf1", of1, e.ovf);
`endif
        last1 = e;
      end
    end else begin
      if (q1.size() != 0) begin
        check_eq("valid1", vo1, 64'd1);
        void'(q1.pop_front());
      end
      check_eq("hold1", {co1, s1}, {last1.c, last1.s[0]});
`ifdef FA_V1_OVERFLOW_EN
      check_eq("hold_ovf1", of1, last1.ovf);
`endif
    end
  end

  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      check_eq("rst8", {vo8, co8, s8}, 64'd0);
      last8 = '0;
    end else if (vo8) begin
      if (q8.size() == 0) begin
        check_eq("spurious_valid8", vo8, 64'd0);
      end else begin
        e = q8.pop_front();
        check_eq("sum8", s8, e.s);
        check_eq("cout8", co8, e.c);
`ifdef FA_V1_OVERFLOW_EN
        check_eq("ovf8", of8, e.ovf);
`endif
        last8 = e;
      end
    end else begin
      if (q8.size() != 0) begin
        check_eq("valid8", vo8, 64'd1);
        void'(q8.pop_front());
      end
      check_eq("hold8", {co8, s8}, {last8.c, last8.s});
`ifdef FA_V1_OVERFLOW_EN
      check_eq("hold_ovf8", of8, last8.ovf);
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // {s, c} for {a, b, c_in} = 0..7
  logic [1:0] tt_sc [8] = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};

  initial begin
    exp_t e;
    logic [2:0] abc;
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    v8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;
    #1 rst_n = 1'b0;

    // Reset holds outputs at zero despite active inputs.
    @(negedge clk);
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    v8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    repeat (3) @(negedge clk);
    v1 = 1'b0; v8 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Full truth table, ending on 111 -> s=1 c=1.
    for (int i = 0; i < 8; i++) begin
      abc   = i[2:0];
      e     = '0;
      e.s   = {7'd0, tt_sc[i][1]};
      e.c   = tt_sc[i][0];
      e.ovf = (abc[2] == abc[1]) && (tt_sc[i][1] != abc[2]);
      step1(1'b1, abc[2], abc[1], abc[0], e);
    end
    // Hold with changed inputs.
    step1(1'b0, 1'b0, 1'b0, 1'b0, '0);
    step1(1'b0, 1'b0, 1'b0, 1'b0, '0);

    // Asynchronous clear between edges.
    @(negedge clk);
    #2 rst_n = 1'b0;
    q1.delete();
    #1 check_eq("async_clr1", {vo1, co1, s1}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Wrap-around and overflow corners.
    step8(1'b1, 8'hFF, 8'h01, 1'b0, '{ovf: 1'b0, c: 1'b1, s: 8'h00});
    step8(1'b1, 8'hFF, 8'hFF, 1'b1, '{ovf: 1'b0, c: 1'b1, s: 8'hFF});
    step8(1'b1, 8'hFF, 8'h00, 1'b1, '{ovf: 1'b0, c: 1'b1, s: 8'h00});
    step8(1'b1, 8'h7F, 8'h01, 1'b0, '{ovf: 1'b1, c: 1'b0, s: 8'h80});
    step8(1'b1, 8'h80, 8'h80, 1'b0, '{ovf: 1'b1, c: 1'b1, s: 8'h00});
    step8(1'b1, 8'h10, 8'h20, 1'b0, '{ovf: 1'b0, c: 1'b0, s: 8'h30});
    step8(1'b0, 8'h00, 8'h00, 1'b0, '0);

    // Random back-to-back stream with a reset pulse in the middle.
    for (int i = 0; i < 100; i++) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      step8(1'b1, ra, rb, rc, exp8(ra, rb, rc));
      if (i == 50) begin
        // Assert before the capturing edge: this pending vector must be lost.
        #2 rst_n = 1'b0;
        q8.delete();
        #1 check_eq("async_clr8", {vo8, co8, s8}, 64'd0);
        @(negedge clk);
        v8 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
      end
    end
    step8(1'b0, 8'h00, 8'h00, 1'b0, '0);
    repeat (2) @(negedge clk);
    check_eq("drain8", q8.size(), 64'd0);
    check_eq("drain1", q1.size(), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
